// File: rtl/load_unit.sv
// Load unit: issues one data-memory read per MEM-stage load, then aligns and extends the result for writeback.
// Optional build macro LOAD_MISALIGN_TRAP_EN makes misaligned LH/LHU/LW fail without issuing a read.
module load_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loadreq_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] addr_mem,
  output logic        rdreq,
  output logic [31:0] rdaddr,
  input  logic        rdvalid,
  input  logic [31:0] rddata,
  output logic        stall_mem,
  output logic [31:0] loaddata_wb,
  output logic        loadvalid_wb,
  output logic        loaderr
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             rdreq_d;
  logic [31:0]      loaddata_d;
  logic             loadvalid_d;
  logic             loaderr_d;

  logic             illegal_c;
  logic             misalign_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      extract_c;

  // Load types the unit accepts; anything else completes immediately with an error.
  always_comb begin
    illegal_c = 1'b1;
    case (funct3_mem)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal_c = 1'b0;
      default:                             illegal_c = 1'b1;
    endcase
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misalign_c = (((funct3_mem == F3_LH) || (funct3_mem == F3_LHU)) && addr_mem[0]) ||
                      ((funct3_mem == F3_LW) && (addr_mem[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Lane select and extension of the returned word, using the registered address and type.
  always_comb begin
    byte_c = rddata[7:0];
    case (addr_q[1:0])
      2'd0:    byte_c = rddata[7:0];
      2'd1:    byte_c = rddata[15:8];
      2'd2:    byte_c = rddata[23:16];
      default: byte_c = rddata[31:24];
    endcase
    half_c = addr_q[1] ? rddata[31:16] : rddata[15:0];
    extract_c = 32'd0;
    case (funct3_q)
      F3_LB:   extract_c = {{24{byte_c[7]}}, byte_c};
      F3_LH:   extract_c = {{16{half_c[15]}}, half_c};
      F3_LW:   extract_c = rddata;
      F3_LBU:  extract_c = {24'd0, byte_c};
      F3_LHU:  extract_c = {16'd0, half_c};
      default: extract_c = 32'd0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    rdreq_d     = 1'b0;
    loadvalid_d = 1'b0;
    loaddata_d  = loaddata_wb;
    loaderr_d   = loaderr;
    case (state_q)
      S_IDLE: begin
        if (loadreq_mem) begin
          addr_d   = addr_mem;
          funct3_d = funct3_mem;
          cnt_d    = '0;
          if (illegal_c || misalign_c) begin
            state_d     = S_DONE;
            loadvalid_d = 1'b1;
            loaderr_d   = 1'b1;
            loaddata_d  = 32'd0;
          end else begin
            state_d = S_REQ;
            rdreq_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving on the last allowed cycle still counts as success.
        if (rdvalid) begin
          state_d     = S_DONE;
          loadvalid_d = 1'b1;
          loaderr_d   = 1'b0;
          loaddata_d  = extract_c;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_DONE;
          loadvalid_d = 1'b1;
          loaderr_d   = 1'b1;
          loaddata_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= 32'd0;
      funct3_q     <= 3'd0;
      rdreq        <= 1'b0;
      loaddata_wb  <= 32'd0;
      loadvalid_wb <= 1'b0;
      loaderr      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      rdreq        <= rdreq_d;
      loaddata_wb  <= loaddata_d;
      loadvalid_wb <= loadvalid_d;
      loaderr      <= loaderr_d;
    end
  end

  assign rdaddr    = {addr_q[31:2], 2'b00};
  assign stall_mem = ((state_q == S_IDLE) && loadreq_mem) || (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: expected results queued at request time, checked on each writeback pulse.
// Expectations follow LOAD_MISALIGN_TRAP_EN when the bench is built with it.
module tb_load_unit;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadreq_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] addr_mem;
  logic        rdreq;
  logic [31:0] rdaddr;
  logic        rdvalid;
  logic [31:0] rddata;
  logic        stall_mem;
  logic [31:0] loaddata_wb;
  logic        loadvalid_wb;
  logic        loaderr;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  int          rdreq_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [31:0] last_rdaddr = 32'd0;
  string       cur_tag = "reset";

  load_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .loadreq_mem  (loadreq_mem),
    .funct3_mem   (funct3_mem),
    .addr_mem     (addr_mem),
    .rdreq        (rdreq),
    .rdaddr       (rdaddr),
    .rdvalid      (rdvalid),
    .rddata       (rddata),
    .stall_mem    (stall_mem),
    .loaddata_wb  (loaddata_wb),
    .loadvalid_wb (loadvalid_wb),
    .loaderr      (loaderr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference result, written independently of the RTL's lane muxes.
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    exp_t        r;
    logic [31:0] sb;
    logic [31:0] sh;
    r.data = 32'd0;
    r.err  = 1'b0;
    sb = d >> {a[1:0], 3'b000};
    sh = d >> {a[1], 4'b0000};
    case (f3)
      3'b000:  r.data = {{24{sb[7]}}, sb[7:0]};
      3'b001:  r.data = {{16{sh[15]}}, sh[15:0]};
      3'b010:  r.data = d;
      3'b100:  r.data = {24'd0, sb[7:0]};
      3'b101:  r.data = {16'd0, sh[15:0]};
      default: r.err  = 1'b1;
    endcase
`ifdef LOAD_MISALIGN_TRAP_EN
    if (((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00)) begin
      r.data = 32'd0;
      r.err  = 1'b1;
    end
`endif
    return r;
  endfunction

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (stall_mem) stall_cnt++;
    if (rdreq) begin
      rdreq_cnt++;
      last_rdaddr = rdaddr;
    end
    if (loadvalid_wb) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb_q.size() == 0) begin
        check({cur_tag, ":unexpected_valid"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({cur_tag, ":data"}, loaddata_wb, e.data);
        check({cur_tag, ":err"}, 32'(loaderr), 32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // dly = WAIT cycle (1-based) carrying rdvalid; 0 = never respond.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int dly);
    exp_t e;
    bit   skip;
    int   c0, sb0, rb0, db0, w, exp_lat, exp_stall;
    e    = model(f3, a, d);
    skip = e.err;
    if (!skip && dly == 0) begin
      e.data = 32'd0;
      e.err  = 1'b1;
    end
    cur_tag = tag;
    sb0 = stall_cnt;
    rb0 = rdreq_cnt;
    db0 = done_cnt;
    sb_q.push_back(e);
    step();
    loadreq_mem = 1'b1;
    funct3_mem  = f3;
    addr_mem    = a;
    c0 = cyc;
    step();
    // Noise while the unit is past IDLE: must be ignored.
    loadreq_mem = 1'b1;
    funct3_mem  = 3'($urandom);
    addr_mem    = $urandom;
    rdvalid     = 1'b1;
    rddata      = $urandom;
    w = 0;
    while (done_cnt == db0 && w < int'(TIMEOUT) + 8) begin
      step();
      loadreq_mem = 1'b0;
      w++;
      rdvalid = (w == dly);
      rddata  = (w == dly) ? d : $urandom;
    end
    rdvalid = 1'b0;
    if (done_cnt == db0) begin
      check({tag, ":valid_seen"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      exp_lat   = skip ? 1 : (dly == 0 ? 2 + int'(TIMEOUT) : 2 + dly);
      exp_stall = skip ? 1 : exp_lat;
      check({tag, ":latency"}, 32'(done_cyc - c0), 32'(exp_lat));
      check({tag, ":stall_cycles"}, 32'(stall_cnt - sb0), 32'(exp_stall));
    end
    check({tag, ":rdreq_count"}, 32'(rdreq_cnt - rb0), skip ? 32'd0 : 32'd1);
    if (!skip) check({tag, ":rdaddr"}, last_rdaddr, {a[31:2], 2'b00});
  endtask

  initial begin
    logic [2:0] legal [5];
    exp_t       m;
    int         db0;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b1;
    loadreq_mem = 1'b0;
    funct3_mem = 3'd0;
    addr_mem = 32'd0;
    rdvalid = 1'b0;
    rddata = 32'd0;
    step();
    step();
    check("reset:rdreq", 32'(rdreq), 32'd0);
    check("reset:rdaddr", rdaddr, 32'd0);
    check("reset:stall", 32'(stall_mem), 32'd0);
    check("reset:loadvalid", 32'(loadvalid_wb), 32'd0);
    check("reset:loaderr", 32'(loaderr), 32'd0);
    check("reset:loaddata", loaddata_wb, 32'd0);
    rst = 1'b0;
    step();

    do_load("lb_103",      3'b000, 32'h0000_0103, 32'h80AA_BBCC, 1);
    do_load("lhu_202",     3'b101, 32'h0000_0202, 32'hBEEF_1234, 5);
    do_load("lw_timeout",  3'b010, 32'h0000_0400, 32'h1111_2222, 0);
    do_load("lw_last_cyc", 3'b010, 32'h0000_0404, 32'hDEAD_BEEF, 16);
    do_load("lw_302",      3'b010, 32'h0000_0302, 32'h1122_3344, 1);
    do_load("illegal_111", 3'b111, 32'h0000_0500, 32'h5555_5555, 0);
    do_load("illegal_011", 3'b011, 32'h0000_0504, 32'h5555_5555, 0);
    do_load("lbu_101",     3'b100, 32'h0000_0101, 32'h1234_5678, 2);
    do_load("lb_102",      3'b000, 32'h0000_0102, 32'h00F0_0000, 1);
    do_load("lh_203",      3'b001, 32'h0000_0203, 32'h8001_7FFF, 3);
    do_load("lh_200",      3'b001, 32'h0000_0200, 32'h7FFF_8001, 1);

    // Result must hold after the writeback pulse.
    m = model(3'b001, 32'h0000_0200, 32'h7FFF_8001);
    repeat (3) step();
    cur_tag = "hold";
    check("hold:loaddata", loaddata_wb, m.data);
    check("hold:loadvalid", 32'(loadvalid_wb), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_load($sformatf("rand%0d", i), legal[$urandom_range(0, 4)], $urandom, $urandom,
              int'($urandom_range(1, 4)));
    end

    do_load("lw_pre_rst", 3'b010, 32'h0000_0600, 32'hCAFE_F00D, 1);

    // Reset while waiting, then a late response that must be dropped.
    cur_tag = "rst_wait";
    db0 = done_cnt;
    step();
    loadreq_mem = 1'b1;
    funct3_mem  = 3'b010;
    addr_mem    = 32'h0000_0700;
    step();
    loadreq_mem = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rdvalid = 1'b1;
    rddata  = 32'h9999_9999;
    step();
    rdvalid = 1'b0;
    check("rst_wait:rdreq", 32'(rdreq), 32'd0);
    check("rst_wait:rdaddr", rdaddr, 32'd0);
    check("rst_wait:stall", 32'(stall_mem), 32'd0);
    check("rst_wait:loadvalid", 32'(loadvalid_wb), 32'd0);
    check("rst_wait:loaderr", 32'(loaderr), 32'd0);
    check("rst_wait:loaddata", loaddata_wb, 32'd0);
    repeat (4) step();
    check("rst_wait:no_valid_pulse", 32'(done_cnt - db0), 32'd0);

    do_load("lb_post_rst", 3'b000, 32'h0000_0103, 32'h80AA_BBCC, 1);
    repeat (2) step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL be the maximum number of cycles spent in WAIT before a load is declared failed (legal range 1..255).
REQ-002 CLK  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 RST  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 LOADREQ_MEM  in  1  SHALL mark a load instruction present in the MEM stage.
REQ-005 FUNCT3_MEM  in  3  SHALL give the load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 ADDR_MEM  in  32  SHALL be the byte address of the load.
REQ-007 RDREQ  out  1  SHALL be the read strobe to data memory.
REQ-008 RDADDR  out  32  SHALL be the word-aligned read address, {addr[31:2],2'b00}.
REQ-009 RDVALID  in  1  SHALL mark the memory response as valid.
REQ-010 RDDATA  in  32  SHALL carry the memory read word.
REQ-011 STALL_MEM  out  1  SHALL freeze IF/ID/EX/MEM while a load is outstanding.
REQ-012 LOADDATA_WB  out  32  SHALL carry the aligned, extended load result.
REQ-013 LOADVALID_WB  out  1  SHALL qualify LOADDATA_WB.
REQ-014 LOADERR  out  1  SHALL flag a failed load (timeout, illegal FUNCT3, or misalignment when trapped).

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE.
REQ-016 In IDLE with LOADREQ_MEM=1, the block SHALL register ADDR_MEM and FUNCT3_MEM, then move to REQ (or to DONE with error per REQ-023/REQ-027).
REQ-017 In REQ, RDREQ SHALL be 1 for exactly one cycle with RDADDR driven from the registered address; the next state SHALL be WAIT.
REQ-018 In WAIT, a cycle counter SHALL increment each cycle; RDVALID=1 SHALL capture RDDATA and move to DONE.
REQ-019 If the counter reaches TIMEOUT with RDVALID=0, the block SHALL move to DONE with LOADERR=1 and LOADDATA_WB=0; if RDVALID=1 in that same cycle, the data SHALL win and no error is raised.
REQ-020 In DONE, LOADVALID_WB SHALL be 1 for exactly one cycle; LOADDATA_WB and LOADERR SHALL hold until the next load's DONE; the next state SHALL be IDLE.
REQ-021 STALL_MEM SHALL be (IDLE and LOADREQ_MEM) or REQ or WAIT; it SHALL be 0 in DONE.
REQ-022 RDVALID outside WAIT SHALL be ignored; LOADREQ_MEM in REQ, WAIT, or DONE SHALL be ignored.
REQ-023 An illegal FUNCT3 (011, 110, 111) SHALL skip REQ/WAIT and go to DONE with LOADERR=1, LOADDATA_WB=0.
REQ-024 Extraction: a byte SHALL be selected by addr[1:0] and a halfword by addr[1]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the word through.
REQ-025 Best-case latency from LOADREQ_MEM in IDLE to LOADVALID_WB SHALL be 3 cycles (IDLE, REQ, WAIT with immediate RDVALID, then DONE).

Reset
REQ-026 RST=1 SHALL force IDLE, clear the counter and all registers, and drive RDREQ, STALL_MEM, LOADVALID_WB, and LOADERR to 0 and RDADDR and LOADDATA_WB to 0; a load in flight SHALL be abandoned, and a late RDVALID after reset SHALL be ignored.

Configuration
REQ-027 Macro LOAD_MISALIGN_TRAP_EN, when defined, SHALL treat LH/LHU with addr[0]=1 and LW with addr[1:0]!=0 as misaligned: no RDREQ is issued, and the block goes IDLE to DONE with LOADERR=1 and LOADDATA_WB=0.
REQ-028 When LOAD_MISALIGN_TRAP_EN is undefined, addr[0] SHALL be ignored for halfwords and addr[1:0] ignored for words, and no misalignment error is raised.

Verification
REQ-029 LB at addr 0x103, RDDATA=0x80AA_BBCC, RDVALID in the first WAIT cycle -> RDADDR=0x100, LOADDATA_WB=0xFFFF_FF80, LOADVALID_WB 3 cycles after the request, LOADERR=0.
REQ-030 LHU at addr 0x202, RDDATA=0xBEEF_1234, RDVALID after 5 WAIT cycles -> LOADDATA_WB=0x0000_BEEF, STALL_MEM high for 7 cycles.
REQ-031 LW with no RDVALID and TIMEOUT=16 -> 16 WAIT cycles, then DONE with LOADERR=1 and LOADDATA_WB=0; a repeat of the test with RDVALID on cycle 16 -> data returned, LOADERR=0.
REQ-032 LW at addr 0x302 -> with LOAD_MISALIGN_TRAP_EN: no RDREQ, LOADERR=1 after 1 cycle; without it: RDADDR=0x300 and the full word is returned.
REQ-033 RST asserted in WAIT, then RDVALID one cycle later -> state IDLE, all outputs 0, no LOADVALID_WB pulse; FUNCT3=111 -> LOADERR=1 and no RDREQ.
